// File: rtl/txt_pkg.sv
// rtl/txt_pkg.sv - shared constants, state encoding and helpers for the text page writer
//
// Purpose: page geometry, bus placement of the text page, the blank screen code,
//          the ASCII control codes the writer reacts to, and the writer state enum.
// Ports:   none (package).
package txt_pkg;

    localparam int          COLS     = 40;
    localparam int          ROWS     = 24;
    localparam logic [15:0] TXT_BASE = 16'h0400;
    localparam logic [7:0]  BLANK    = 8'hA0;

    localparam logic [7:0]  CR = 8'h0D;
    localparam logic [7:0]  LF = 8'h0A;
    localparam logic [7:0]  BS = 8'h08;
    localparam logic [7:0]  FF = 8'h0C;

    localparam logic [5:0]  COL_LAST    = 6'(COLS - 1);
    localparam logic [4:0]  ROW_LAST    = 5'(ROWS - 1);
    // Last destination cell of a scroll copy; the bottom row is blanked afterwards.
    localparam logic [9:0]  SCROLL_LAST = 10'((ROWS - 1) * COLS - 1);
    localparam logic [9:0]  CELL_LAST   = 10'(COLS * ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        ADV_NL,
        SCROLL,
        CLRROW,
        CLEAR
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    function automatic logic [9:0] cell_idx(input logic [4:0] row, input logic [5:0] col);
        return 10'(row) * 10'(COLS) + 10'(col);
    endfunction

endpackage

// File: rtl/txt_writer_if.sv
// rtl/txt_writer_if.sv - character stream handshake into the text page writer
//
// Purpose: groups the valid/ready character stream.
// Signals: ch_valid (character offered), ch_data (ASCII), ch_ready (writer can accept).
// Modports: master drives characters, slave (the writer) accepts them.
interface txt_writer_if;
    logic       ch_valid;
    logic [7:0] ch_data;
    logic       ch_ready;

    modport master (output ch_valid, output ch_data, input ch_ready);
    modport slave  (input ch_valid, input ch_data, output ch_ready);
endinterface

// File: rtl/txt_charmap.sv
// rtl/txt_charmap.sv - combinational ASCII to screen code conversion
//
// Purpose: maps printable ASCII 0x20-0x7E onto screen codes.
//          TXT_WRITER_LCASE_EN defined: 0x60-0x7E map to the alternate-charset lower case.
//          TXT_WRITER_LCASE_EN undefined: 0x60-0x7E fold onto upper case.
// Ports:   ch_i   - ASCII input
//          code_o - screen code (non-printable codes pass through unchanged)
module txt_charmap (
    input  logic [7:0] ch_i,
    output logic [7:0] code_o
);

    always_comb begin
        code_o = ch_i;
        if (ch_i >= 8'h20 && ch_i <= 8'h5F) begin
            code_o = ch_i | 8'h80;
        end else if (ch_i >= 8'h60 && ch_i <= 8'h7E) begin
`ifdef TXT_WRITER_LCASE_EN
            code_o = ch_i | 8'h80;
`else
            code_o = (ch_i - 8'h20) | 8'h80;
`endif
        end
    end

endmodule

// File: rtl/txt_writer.sv
// rtl/txt_writer.sv - writer side of the 40x24 text page
//
// Purpose: accepts ASCII characters, keeps a cursor, writes screen codes into the
//          text buffer, and handles newline, backspace, form-feed clear and scroll.
//          Lower-case mapping is selected by TXT_WRITER_LCASE_EN (see txt_charmap).
// Ports:   CLOCK_50  - system clock
//          reset     - synchronous, active-high
//          ch        - character stream (slave side)
//          mem_we    - buffer write strobe
//          mem_adr   - write address, TXT_BASE + idx
//          mem_wdata - write data
//          mem_radr  - scroll source address, one row below mem_adr
//          mem_rdata - buffer read data, combinational from mem_radr
//          cur_col   - cursor column
//          cur_row   - cursor row
//          busy      - writer cannot accept a character
module txt_writer
    import txt_pkg::*;
(
    input  logic         CLOCK_50,
    input  logic         reset,
    txt_writer_if.slave  ch,
    output logic         mem_we,
    output logic [15:0]  mem_adr,
    output logic [7:0]   mem_wdata,
    output logic [15:0]  mem_radr,
    input  logic [7:0]   mem_rdata,
    output logic [5:0]   cur_col,
    output logic [4:0]   cur_row,
    output logic         busy
);

    state_t     state_q, state_d;
    logic [9:0] idx_q, idx_d;
    logic [7:0] chr_q, chr_d;
    logic [5:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [7:0] code;

    txt_charmap u_charmap (
        .ch_i   (ch.ch_data),
        .code_o (code)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            chr_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            chr_q   <= chr_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        chr_d   = chr_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (ch.ch_valid) begin
                    if (is_printable(ch.ch_data)) begin
                        chr_d   = code;
                        idx_d   = cell_idx(row_q, col_q);
                        state_d = PUT;
                    end else if (ch.ch_data == CR || ch.ch_data == LF) begin
                        state_d = ADV_NL;
                    end else if (ch.ch_data == BS) begin
                        // Backspace only moves the cursor; the cell is left as is.
                        if (col_q != '0) begin
                            col_d = col_q - 6'd1;
                        end else if (row_q != '0) begin
                            col_d = COL_LAST;
                            row_d = row_q - 5'd1;
                        end
                    end else if (ch.ch_data == FF) begin
                        col_d   = '0;
                        row_d   = '0;
                        idx_d   = '0;
                        state_d = CLEAR;
                    end
                end
            end
            PUT, ADV_NL: begin
                // PUT advances one column unless at the right edge; both wrap to a new line.
                if (state_q == PUT && col_q != COL_LAST) begin
                    col_d   = col_q + 6'd1;
                    state_d = IDLE;
                end else begin
                    col_d = '0;
                    if (row_q != ROW_LAST) begin
                        row_d   = row_q + 5'd1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = SCROLL;
                    end
                end
            end
            SCROLL: begin
                idx_d = idx_q + 10'd1;
                if (idx_q == SCROLL_LAST) begin
                    state_d = CLRROW;
                end
            end
            CLRROW, CLEAR: begin
                if (idx_q == CELL_LAST) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 10'd1;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = CLEAR;
            end
        endcase
    end

    always_comb begin
        mem_we   = (state_q == PUT) || (state_q == SCROLL) ||
                   (state_q == CLRROW) || (state_q == CLEAR);
        mem_adr  = TXT_BASE + {6'b0, idx_q};
        // The copy source is the same column one row further down.
        mem_radr = TXT_BASE + {6'b0, idx_q} + 16'(COLS);
        case (state_q)
            PUT:     mem_wdata = chr_q;
            SCROLL:  mem_wdata = mem_rdata;
            default: mem_wdata = BLANK;
        endcase
        ch.ch_ready = (state_q == IDLE);
        busy        = (state_q != IDLE);
        cur_col     = col_q;
        cur_row     = row_q;
    end

endmodule

// File: tb/tb_txt_writer.sv
// tb/tb_txt_writer.sv - self-checking bench for txt_writer
module tb_txt_writer;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        mem_we;
    logic [15:0] mem_adr;
    logic [7:0]  mem_wdata;
    logic [15:0] mem_radr;
    logic [7:0]  mem_rdata;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;
    logic        fill_req = 1'b0;

    logic [7:0]  tbmem [0:2047];
    logic [23:0] wlog [$];

    int n_pass  = 0;
    int n_total = 0;

`ifdef TXT_WRITER_LCASE_EN
    localparam bit LC = 1'b1;
`else
    localparam bit LC = 1'b0;
`endif

    typedef struct {
        logic [7:0]  c;
        logic        we;
        logic [15:0] adr;
        logic [7:0]  wd;
        int          col;
        int          row;
    } vec_t;

    vec_t tv [16];

    txt_writer_if ch ();

    always #10 CLOCK_50 = ~CLOCK_50;

    txt_writer dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .ch        (ch),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_radr  (mem_radr),
        .mem_rdata (mem_rdata),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .busy      (busy)
    );

    assign mem_rdata = tbmem[mem_radr[10:0]];

    always @(posedge CLOCK_50) begin
        if (mem_we === 1'b1) begin
            tbmem[mem_adr[10:0]] <= mem_wdata;
            wlog.push_back({mem_adr, mem_wdata});
        end
        if (fill_req) begin
            for (int i = 0; i < 960; i++) tbmem[1024 + i] <= 8'($urandom);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (ch.ch_ready !== 1'b1 && cyc < 3000) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        if (cyc >= 3000) chk("ready_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        wait_ready(n);
        ch.ch_valid = 1'b1;
        ch.ch_data  = c;
        @(negedge CLOCK_50);
        ch.ch_valid = 1'b0;
    endtask

    task automatic chk_cursor(input string nm, input int col, input int row);
        chk({nm, "_col"}, 32'(cur_col), 32'(col));
        chk({nm, "_row"}, 32'(cur_row), 32'(row));
    endtask

    // Expects the log to hold exactly one full-page blank pass in address order.
    task automatic chk_clear_log(input string nm);
        int errs = 0;
        chk({nm, "_nwrites"}, 32'(wlog.size()), 32'd960);
        for (int i = 0; i < wlog.size() && i < 960; i++)
            if (wlog[i] !== {16'h0400 + 16'(i), 8'hA0}) errs++;
        chk({nm, "_order"}, 32'(errs), 32'd0);
    endtask

    function automatic logic [7:0] cmap(input logic [7:0] c);
        if (c < 8'h60) return c | 8'h80;
        return LC ? (c | 8'h80) : ((c - 8'h20) | 8'h80);
    endfunction

    initial begin
        int          cyc;
        int          errs;
        int          n;
        logic [7:0]  c;
        logic [7:0]  snap [960];

        tv[0]  = '{8'h48, 1'b1, 16'h0400, 8'hC8, 1, 0};
        tv[1]  = '{8'h61, 1'b1, 16'h0401, LC ? 8'hE1 : 8'hC1, 2, 0};
        tv[2]  = '{8'h7E, 1'b1, 16'h0402, LC ? 8'hFE : 8'hDE, 3, 0};
        tv[3]  = '{8'h20, 1'b1, 16'h0403, 8'hA0, 4, 0};
        tv[4]  = '{8'h5F, 1'b1, 16'h0404, 8'hDF, 5, 0};
        tv[5]  = '{8'h08, 1'b0, 16'h0000, 8'h00, 4, 0};
        tv[6]  = '{8'h07, 1'b0, 16'h0000, 8'h00, 4, 0};
        tv[7]  = '{8'h7F, 1'b0, 16'h0000, 8'h00, 4, 0};
        tv[8]  = '{8'h0A, 1'b0, 16'h0000, 8'h00, 0, 1};
        tv[9]  = '{8'h60, 1'b1, 16'h0428, LC ? 8'hE0 : 8'hC0, 1, 1};
        tv[10] = '{8'h08, 1'b0, 16'h0000, 8'h00, 0, 1};
        tv[11] = '{8'h08, 1'b0, 16'h0000, 8'h00, 39, 0};
        tv[12] = '{8'h31, 1'b1, 16'h0427, 8'hB1, 0, 1};
        tv[13] = '{8'h0D, 1'b0, 16'h0000, 8'h00, 0, 2};
        tv[14] = '{8'h0C, 1'b1, 16'h0400, 8'hA0, 0, 0};
        tv[15] = '{8'h08, 1'b0, 16'h0000, 8'h00, 0, 0};

        ch.ch_valid = 1'b0;
        ch.ch_data  = 8'h00;

        // Reset held: cell 0 rewritten with blank every cycle, not ready.
        repeat (3) @(negedge CLOCK_50);
        chk("rst_ready", 32'(ch.ch_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd1);
        chk("rst_adr", 32'(mem_adr), 32'h0400);
        chk("rst_wdata", 32'(mem_wdata), 32'hA0);
        chk_cursor("rst", 0, 0);
        reset = 1'b0;
        wlog.delete();
        wait_ready(cyc);
        chk("rst_ready_cycles", 32'(cyc), 32'd960);
        chk_clear_log("rst_clear");
        chk_cursor("rst_done", 0, 0);

        // Single-character vectors from (0,0).
        for (int i = 0; i < 16; i++) begin
            send(tv[i].c);
            chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(tv[i].we));
            if (tv[i].we) begin
                chk($sformatf("v%0d_adr", i), 32'(mem_adr), 32'(tv[i].adr));
                chk($sformatf("v%0d_wdata", i), 32'(mem_wdata), 32'(tv[i].wd));
            end
            wait_ready(cyc);
            chk_cursor($sformatf("v%0d", i), tv[i].col, tv[i].row);
        end

        // A full row of printables wraps to the next line.
        for (int i = 0; i < 40; i++) begin
            c = (i < 26) ? 8'h41 + 8'(i) : 8'h61 + 8'(i - 26);
            send(c);
            if (i == 39) begin
                chk("row_last_adr", 32'(mem_adr), 32'h0427);
                chk("row_last_wdata", 32'(mem_wdata), 32'(cmap(c)));
            end
        end
        wait_ready(cyc);
        chk_cursor("row_wrap", 0, 1);
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            c = (i < 26) ? 8'h41 + 8'(i) : 8'h61 + 8'(i - 26);
            if (tbmem[1024 + i] !== cmap(c)) errs++;
        end
        chk("row_contents", 32'(errs), 32'd0);
        send(8'h08);
        chk("bs_wrap_we", 32'(mem_we), 32'd0);
        chk_cursor("bs_wrap", 39, 0);

        // Walk down to (5,23), then newline forces a scroll.
        for (int i = 0; i < 23; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h78);
        wait_ready(cyc);
        chk_cursor("pre_scroll", 5, 23);
        fill_req = 1'b1;
        @(negedge CLOCK_50);
        fill_req = 1'b0;
        for (int i = 0; i < 960; i++) snap[i] = tbmem[1024 + i];
        wlog.delete();
        send(8'h0D);
        wait_ready(cyc);
        chk("scroll_cycles", 32'(cyc), 32'd961);
        chk_cursor("scroll", 0, 23);
        chk("scroll_nwrites", 32'(wlog.size()), 32'd960);
        errs = 0;
        for (int i = 0; i < wlog.size() && i < 960; i++)
            if (wlog[i] !== {16'h0400 + 16'(i), (i < 920) ? snap[i + 40] : 8'hA0}) errs++;
        chk("scroll_data", 32'(errs), 32'd0);

        // Character held valid through a scroll is taken once, in the first IDLE cycle.
        wlog.delete();
        send(8'h0A);
        ch.ch_valid = 1'b1;
        ch.ch_data  = 8'h41;
        n = 0;
        while (ch.ch_ready !== 1'b1 && n < 3000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("hold_wait", 32'(n), 32'd961);
        chk_cursor("hold_pre", 0, 23);
        @(negedge CLOCK_50);
        ch.ch_valid = 1'b0;
        chk("hold_we", 32'(mem_we), 32'd1);
        chk("hold_adr", 32'(mem_adr), 32'h0798);
        chk("hold_wdata", 32'(mem_wdata), 32'hC1);
        wait_ready(cyc);
        repeat (3) @(negedge CLOCK_50);
        errs = 0;
        foreach (wlog[i]) if (wlog[i] === {16'h0798, 8'hC1}) errs++;
        chk("hold_once", 32'(errs), 32'd1);
        chk("hold_nwrites", 32'(wlog.size()), 32'd961);
        chk_cursor("hold_post", 1, 23);

        // Reset in the middle of a scroll restarts the full clear.
        send(8'h0A);
        repeat (301) @(negedge CLOCK_50);
        chk("mid_we", 32'(mem_we), 32'd1);
        chk("mid_adr", 32'(mem_adr), 32'h052C);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("mid_rst_ready", 32'(ch.ch_ready), 32'd0);
        chk("mid_rst_adr", 32'(mem_adr), 32'h0400);
        chk("mid_rst_wdata", 32'(mem_wdata), 32'hA0);
        chk_cursor("mid_rst", 0, 0);
        reset = 1'b0;
        wlog.delete();
        wait_ready(cyc);
        chk("mid_ready_cycles", 32'(cyc), 32'd960);
        chk_clear_log("mid_clear");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
